// File: rtl/lap_timer.sv
// lap_timer: MM:SS.cc up/down stopwatch with a circular lap buffer,
// stopped-state lap recall, countdown expiry and six active-low 7-seg digits.
module lap_timer #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int LAP_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_stop,
    input  logic                         zero,
    input  logic                         lap,
    input  logic                         mode,
    input  logic [5:0]                   preset_min,
    input  logic [5:0]                   preset_sec,
    output logic [6:0]                   HEX0,
    output logic [6:0]                   HEX1,
    output logic [6:0]                   HEX2,
    output logic [6:0]                   HEX3,
    output logic [6:0]                   HEX4,
    output logic [6:0]                   HEX5,
    output logic                         running,
    output logic                         expired,
    output logic                         recall,
    output logic [$clog2(LAP_DEPTH):0]   lap_count
);

    localparam int DIV = CLOCK_FREQ / 100;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW  = $clog2(LAP_DEPTH);
    localparam int CW  = PW + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] LAP_FULL = CW'(LAP_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, RECALL, EXPIRED} state_t;

    typedef struct packed {
        logic [5:0] min;
        logic [5:0] sec;
        logic [6:0] cs;
    } lap_time_t;

    state_t              state_reg, state_next;
    lap_time_t           cur_reg, cur_next;
    logic                dir_reg, dir_next;
    logic [DW-1:0]       div_reg, div_next;
    logic [PW-1:0]       wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0]       lap_count_reg, lap_count_next;
    logic [PW-1:0]       view_reg, view_next;
    logic [PW-1:0]       age_reg, age_next;
    logic                ss_prev_reg, zero_prev_reg, lap_prev_reg;
    logic                wr_en;
    lap_time_t           rd_data_reg;
    lap_time_t           lap_mem [LAP_DEPTH];

    logic                ev_ss, ev_zero, ev_lap, tick;
    lap_time_t           preset_time, clear_time, shown;
    logic [3:0]          digit [6];
    logic [6:0]          seg [6];

    // Advance by one centisecond, 59:59.99 rolls over to 00:00.00.
    function automatic lap_time_t count_up(input lap_time_t t);
        lap_time_t r;
        r = t;
        if (t.cs != 7'd99) begin
            r.cs = t.cs + 7'd1;
        end else begin
            r.cs = 7'd0;
            if (t.sec != 6'd59) begin
                r.sec = t.sec + 6'd1;
            end else begin
                r.sec = 6'd0;
                r.min = (t.min == 6'd59) ? 6'd0 : t.min + 6'd1;
            end
        end
        return r;
    endfunction

    // Step back one centisecond; only called on a nonzero time.
    function automatic lap_time_t count_down(input lap_time_t t);
        lap_time_t r;
        r = t;
        if (t.cs != 7'd0) begin
            r.cs = t.cs - 7'd1;
        end else begin
            r.cs = 7'd99;
            if (t.sec != 6'd0) begin
                r.sec = t.sec - 6'd1;
            end else begin
                r.sec = 6'd59;
                r.min = t.min - 6'd1;
            end
        end
        return r;
    endfunction

    // Binary 0..99 to {tens, ones} BCD.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    // Active-low {g..a} pattern for one decimal digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    assign ev_ss   = start_stop & ~ss_prev_reg;
    assign ev_zero = zero & ~zero_prev_reg;
    assign ev_lap  = lap & ~lap_prev_reg;
    assign tick    = (state_reg == RUN) && (div_reg == DIV_LAST);

    assign preset_time.min = (preset_min > 6'd59) ? 6'd59 : preset_min;
    assign preset_time.sec = (preset_sec > 6'd59) ? 6'd59 : preset_sec;
    assign preset_time.cs  = 7'd0;
    assign clear_time      = mode ? preset_time : '0;

    // Next-state, time, divider and lap-buffer pointer logic.
    always_comb begin
        state_next     = state_reg;
        cur_next       = cur_reg;
        dir_next       = dir_reg;
        wr_ptr_next    = wr_ptr_reg;
        lap_count_next = lap_count_reg;
        view_next      = view_reg;
        age_next       = age_reg;
        wr_en          = 1'b0;
        div_next       = '0;
        if (state_reg == RUN) begin
            div_next = tick ? '0 : div_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (ev_zero) begin
                    cur_next       = clear_time;
                    wr_ptr_next    = '0;
                    lap_count_next = '0;
                end else if (ev_ss) begin
                    // A countdown from 00:00.00 has nothing to count.
                    if (!(mode && (cur_reg == '0))) begin
                        state_next = RUN;
                        dir_next   = mode;
                    end
                end else if (ev_lap && (lap_count_reg != '0)) begin
                    state_next = RECALL;
                    view_next  = wr_ptr_reg - 1'b1;
                    age_next   = '0;
                end
            end
            RUN: begin
                if (ev_zero) begin
                    state_next     = IDLE;
                    cur_next       = clear_time;
                    wr_ptr_next    = '0;
                    lap_count_next = '0;
                end else if (ev_ss) begin
                    // Any tick in this cycle is dropped so the stop edge freezes time.
                    state_next = IDLE;
                end else begin
                    if (tick) begin
                        if (dir_reg) begin
                            cur_next = count_down(cur_reg);
                            if (cur_reg.min == 6'd0 && cur_reg.sec == 6'd0 && cur_reg.cs == 7'd1) begin
                                state_next = EXPIRED;
                            end
                        end else begin
                            cur_next = count_up(cur_reg);
                        end
                    end
                    if (ev_lap) begin
                        wr_en       = 1'b1;
                        wr_ptr_next = wr_ptr_reg + 1'b1;
                        if (lap_count_reg != LAP_FULL) begin
                            lap_count_next = lap_count_reg + 1'b1;
                        end
                    end
                end
            end
            RECALL: begin
                if (ev_zero) begin
                    state_next     = IDLE;
                    cur_next       = clear_time;
                    wr_ptr_next    = '0;
                    lap_count_next = '0;
                end else if (ev_ss) begin
                    state_next = IDLE;
                end else if (ev_lap) begin
                    // Walk to the next older valid lap, wrapping back to the newest.
                    if ((CW'(age_reg) + CW'(1)) == lap_count_reg) begin
                        age_next  = '0;
                        view_next = wr_ptr_reg - 1'b1;
                    end else begin
                        age_next  = age_reg + 1'b1;
                        view_next = view_reg - 1'b1;
                    end
                end
            end
            EXPIRED: begin
                if (ev_zero) begin
                    state_next = IDLE;
                    cur_next   = preset_time;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cur_reg       <= '0;
            dir_reg       <= 1'b0;
            div_reg       <= '0;
            wr_ptr_reg    <= '0;
            lap_count_reg <= '0;
            view_reg      <= '0;
            age_reg       <= '0;
            ss_prev_reg   <= 1'b0;
            zero_prev_reg <= 1'b0;
            lap_prev_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cur_reg       <= cur_next;
            dir_reg       <= dir_next;
            div_reg       <= div_next;
            wr_ptr_reg    <= wr_ptr_next;
            lap_count_reg <= lap_count_next;
            view_reg      <= view_next;
            age_reg       <= age_next;
            ss_prev_reg   <= start_stop;
            zero_prev_reg <= zero;
            lap_prev_reg  <= lap;
        end
    end

    // Lap storage RAM; the read follows the next view so it lines up with view_reg.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lap_mem[wr_ptr_reg] <= cur_reg;
        end
        rd_data_reg <= lap_mem[view_next];
    end

    assign shown = (state_reg == RECALL) ? rd_data_reg : cur_reg;

    // Split the displayed time into six BCD digits, least significant first.
    always_comb begin
        logic [7:0] b_cs, b_sec, b_min;
        b_cs     = to_bcd(shown.cs);
        b_sec    = to_bcd({1'b0, shown.sec});
        b_min    = to_bcd({1'b0, shown.min});
        digit[0] = b_cs[3:0];
        digit[1] = b_cs[7:4];
        digit[2] = b_sec[3:0];
        digit[3] = b_sec[7:4];
        digit[4] = b_min[3:0];
        digit[5] = b_min[7:4];
    end

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_seg
            assign seg[gi] = seg7(digit[gi]);
        end
    endgenerate

    assign HEX0      = seg[0];
    assign HEX1      = seg[1];
    assign HEX2      = seg[2];
    assign HEX3      = seg[3];
    assign HEX4      = seg[4];
    assign HEX5      = seg[5];
    assign running   = (state_reg == RUN);
    assign expired   = (state_reg == EXPIRED);
    assign recall    = (state_reg == RECALL);
    assign lap_count = lap_count_reg;

endmodule

// File: tb/tb_lap_timer.sv
// tb_lap_timer: directed scenarios for lap_timer, one task per feature.
module tb_lap_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start_stop, zero, lap, mode;
    logic [5:0] preset_min, preset_sec;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic       running, expired, recall;
    logic [2:0] lap_count;

    logic       rst_n_b, start_b;
    logic       zero_b = 1'b0, lap_b = 1'b0, mode_b = 1'b0;
    logic [6:0] hb0, hb1, hb2, hb3, hb4, hb5;
    logic       running_b, expired_b, recall_b;
    logic [2:0] lap_count_b;

    logic [41:0] hex_a, hex_b;
    assign hex_a = {hex5, hex4, hex3, hex2, hex1, hex0};
    assign hex_b = {hb5, hb4, hb3, hb2, hb1, hb0};

    localparam logic [41:0] HEX_ZERO = {6{7'h40}};

    int total = 0;
    int bad   = 0;

    lap_timer #(.CLOCK_FREQ(100), .LAP_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .zero(zero), .lap(lap),
        .mode(mode), .preset_min(preset_min), .preset_sec(preset_sec),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5),
        .running(running), .expired(expired), .recall(recall), .lap_count(lap_count)
    );

    lap_timer #(.CLOCK_FREQ(1000), .LAP_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .start_stop(start_b), .zero(zero_b), .lap(lap_b),
        .mode(mode_b), .preset_min(6'd0), .preset_sec(6'd0),
        .HEX0(hb0), .HEX1(hb1), .HEX2(hb2), .HEX3(hb3), .HEX4(hb4), .HEX5(hb5),
        .running(running_b), .expired(expired_b), .recall(recall_b), .lap_count(lap_count_b)
    );

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [41:0] exp_hex(input int m, input int s, input int c);
        return {seg(m / 10), seg(m % 10), seg(s / 10), seg(s % 10), seg(c / 10), seg(c % 10)};
    endfunction

    // Raise the chosen inputs for one cycle; the event acts on the edge this returns after.
    task automatic pulse(input logic s, input logic z, input logic l);
        start_stop = s; zero = z; lap = l;
        @(posedge clk); #1;
        start_stop = 1'b0; zero = 1'b0; lap = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rst_n_b = 1'b0; start_b = 1'b0;
        start_stop = 1'b0; zero = 1'b0; lap = 1'b0; mode = 1'b0;
        preset_min = 6'd0; preset_sec = 6'd0;
        wait_cycles(2);
        total++; if (hex_a !== HEX_ZERO) begin bad++; $display("FAIL reset_hex got=%h exp=%h", hex_a, HEX_ZERO); end
        total++; if ({running, expired, recall} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {running, expired, recall}); end
        total++; if (lap_count !== 3'd0) begin bad++; $display("FAIL reset_lap_count got=%0d exp=0", lap_count); end
        rst_n = 1'b1; rst_n_b = 1'b1;
        wait_cycles(1);
        $display("reset: display 000000, flags clear");
    endtask

    task automatic test_basic;
        mode = 1'b0;
        pulse(1, 0, 0);
        total++; if (running !== 1'b1) begin bad++; $display("FAIL basic_running got=%b exp=1", running); end
        wait_cycles(250);
        pulse(1, 0, 0);
        total++; if (hex_a !== exp_hex(0, 2, 50)) begin bad++; $display("FAIL basic_stop got=%h exp=%h", hex_a, exp_hex(0, 2, 50)); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL basic_stopped got=%b exp=0", running); end
        wait_cycles(100);
        total++; if (hex_a !== exp_hex(0, 2, 50)) begin bad++; $display("FAIL basic_hold got=%h exp=%h", hex_a, exp_hex(0, 2, 50)); end
        $display("basic: 250 ticks -> 00:02.50 held");
    endtask

    task automatic test_up_wrap;
        mode = 1'b1; preset_min = 6'd63; preset_sec = 6'd60;
        pulse(0, 1, 0);
        total++; if (hex_a !== exp_hex(59, 59, 0)) begin bad++; $display("FAIL clamp_preset got=%h exp=%h", hex_a, exp_hex(59, 59, 0)); end
        mode = 1'b0;
        pulse(1, 0, 0);
        wait_cycles(99);
        pulse(1, 0, 0);
        total++; if (hex_a !== exp_hex(59, 59, 99)) begin bad++; $display("FAIL wrap_max got=%h exp=%h", hex_a, exp_hex(59, 59, 99)); end
        wait_cycles(1);
        pulse(1, 0, 0);
        wait_cycles(2);
        pulse(1, 0, 0);
        total++; if (hex_a !== exp_hex(0, 0, 1)) begin bad++; $display("FAIL wrap_over got=%h exp=%h", hex_a, exp_hex(0, 0, 1)); end
        total++; if (expired !== 1'b0) begin bad++; $display("FAIL wrap_no_expire got=%b exp=0", expired); end
        $display("up_wrap: 59:59.99 -> 00:00.01");
    endtask

    task automatic test_laps;
        mode = 1'b0;
        pulse(0, 1, 0);
        pulse(1, 0, 0);
        wait_cycles(100);
        pulse(0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            wait_cycles(99);
            pulse(0, 0, 1);
        end
        total++; if (lap_count !== 3'd4) begin bad++; $display("FAIL lap_saturate got=%0d exp=4", lap_count); end
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        total++; if (recall !== 1'b1) begin bad++; $display("FAIL recall_enter got=%b exp=1", recall); end
        total++; if (hex_a !== exp_hex(0, 5, 0)) begin bad++; $display("FAIL recall_0 got=%h exp=%h", hex_a, exp_hex(0, 5, 0)); end
        for (int i = 1; i <= 4; i++) begin
            int s_exp;
            s_exp = (i == 4) ? 5 : 5 - i;
            wait_cycles(1);
            pulse(0, 0, 1);
            total++; if (hex_a !== exp_hex(0, s_exp, 0)) begin bad++; $display("FAIL recall_%0d got=%h exp=%h", i, hex_a, exp_hex(0, s_exp, 0)); end
        end
        pulse(1, 0, 0);
        total++; if (recall !== 1'b0 || hex_a !== exp_hex(0, 5, 1)) begin bad++; $display("FAIL recall_exit got=%b/%h exp=0/%h", recall, hex_a, exp_hex(0, 5, 1)); end
        $display("laps: recall 5.00 4.00 3.00 2.00 5.00");
    endtask

    task automatic test_countdown;
        mode = 1'b1; preset_min = 6'd0; preset_sec = 6'd2;
        pulse(0, 1, 0);
        total++; if (hex_a !== exp_hex(0, 2, 0) || lap_count !== 3'd0) begin bad++; $display("FAIL cd_load got=%h/%0d exp=%h/0", hex_a, lap_count, exp_hex(0, 2, 0)); end
        pulse(1, 0, 0);
        wait_cycles(199);
        total++; if (hex_a !== exp_hex(0, 0, 1) || expired !== 1'b0) begin bad++; $display("FAIL cd_last got=%h/%b exp=%h/0", hex_a, expired, exp_hex(0, 0, 1)); end
        wait_cycles(1);
        total++; if (hex_a !== HEX_ZERO || expired !== 1'b1 || running !== 1'b0) begin bad++; $display("FAIL cd_expire got=%h/%b/%b exp=%h/1/0", hex_a, expired, running, HEX_ZERO); end
        wait_cycles(1);
        pulse(1, 0, 0);
        wait_cycles(2);
        total++; if (expired !== 1'b1 || running !== 1'b0 || hex_a !== HEX_ZERO) begin bad++; $display("FAIL cd_ignore_start got=%b/%b/%h exp=1/0/%h", expired, running, hex_a, HEX_ZERO); end
        pulse(0, 1, 0);
        total++; if (hex_a !== exp_hex(0, 2, 0) || expired !== 1'b0 || running !== 1'b0) begin bad++; $display("FAIL cd_reload got=%h/%b/%b exp=%h/0/0", hex_a, expired, running, exp_hex(0, 2, 0)); end
        $display("countdown: 00:02.00 -> expired -> reload");
    endtask

    task automatic test_simultaneous;
        mode = 1'b0;
        pulse(1, 0, 0);
        wait_cycles(10);
        pulse(0, 0, 1);
        total++; if (lap_count !== 3'd1) begin bad++; $display("FAIL sim_lap got=%0d exp=1", lap_count); end
        wait_cycles(10);
        pulse(1, 1, 0);
        total++; if (hex_a !== HEX_ZERO || running !== 1'b0 || lap_count !== 3'd0) begin bad++; $display("FAIL sim_zero_wins got=%h/%b/%0d exp=%h/0/0", hex_a, running, lap_count, HEX_ZERO); end
        mode = 1'b1;
        wait_cycles(1);
        pulse(1, 0, 0);
        total++; if (running !== 1'b0) begin bad++; $display("FAIL cd_from_zero got=%b exp=0", running); end
        mode = 1'b0;
        $display("simultaneous: zero beats start_stop");
    endtask

    task automatic test_divider;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        wait_cycles(9);
        total++; if (hex_b !== exp_hex(0, 0, 0)) begin bad++; $display("FAIL div_before got=%h exp=%h", hex_b, exp_hex(0, 0, 0)); end
        wait_cycles(1);
        total++; if (hex_b !== exp_hex(0, 0, 1)) begin bad++; $display("FAIL div_first got=%h exp=%h", hex_b, exp_hex(0, 0, 1)); end
        wait_cycles(9);
        total++; if (hex_b !== exp_hex(0, 0, 1)) begin bad++; $display("FAIL div_hold got=%h exp=%h", hex_b, exp_hex(0, 0, 1)); end
        wait_cycles(1);
        total++; if (hex_b !== exp_hex(0, 0, 2)) begin bad++; $display("FAIL div_second got=%h exp=%h", hex_b, exp_hex(0, 0, 2)); end
        rst_n_b = 1'b0;
        wait_cycles(1);
        total++; if (hex_b !== HEX_ZERO || {running_b, expired_b, recall_b} !== 3'b000 || lap_count_b !== 3'd0) begin
            bad++; $display("FAIL mid_run_reset got=%h/%b/%0d exp=%h/000/0", hex_b, {running_b, expired_b, recall_b}, lap_count_b, HEX_ZERO);
        end
        rst_n_b = 1'b1;
        $display("divider: cs every 10 cycles, reset mid-run");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_up_wrap();
        test_laps();
        test_countdown();
        test_simultaneous();
        test_divider();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lap_timer.md
Name: lap_timer

Overview:
Parametrised successor to the board stopwatch. Counts MM:SS.cc (centiseconds) up, or down from a preset, and drives six active-low 7-segment digits. Adds a circular lap buffer with stopped-state recall and a countdown-expiry flag. Sits between the debounced board push-buttons/switches and the HEX displays.

Parameters:
CLOCK_FREQ, 50_000_000, clk frequency in Hz; must be a multiple of 100 and >= 100.
LAP_DEPTH, 4, number of stored lap times; power of two, 2..16.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
start_stop  in  1  level, synchronous to clk; acts on rising edge
zero  in  1  level; acts on rising edge
lap  in  1  level; acts on rising edge
mode  in  1  0 = count up, 1 = count down; sampled only while stopped
preset_min  in  6  countdown start minutes, binary 0..59 (values >59 clamp to 59)
preset_sec  in  6  countdown start seconds, binary 0..59 (values >59 clamp to 59)
HEX0..HEX5  out  7 each  active-low segments {g..a}: HEX1:HEX0 = cs, HEX3:HEX2 = s, HEX5:HEX4 = min
running  out  1  1 in RUN
expired  out  1  1 in EXPIRED
recall  out  1  1 in RECALL (display shows a stored lap)
lap_count  out  $clog2(LAP_DEPTH)+1  number of valid laps stored, saturates at LAP_DEPTH

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; time = 00:00.00; divider = 0; lap buffer is invalidated; lap_count=0; edge registers=0; running=expired=recall=0; HEX shows "000000" (0x40 on each digit).
- Edge detect: each input is registered once; event = in & ~prev. Event in cycle n takes effect at edge n+1.
- Tick: divider counts 0..DIV-1, DIV = CLOCK_FREQ/100. Tick is asserted when divider = DIV-1, in RUN only. Divider is cleared on every transition into RUN. The first tick therefore occurs DIV cycles after the start edge.
- Time is held as binary cs(0..99), s(0..59), min(0..59). Up: cs wraps to s, s wraps to min, and 59:59.99 wraps to 00:00.00. Down: 00:00.01 -> 00:00.00, then go to EXPIRED. Digits are binary-to-BCD converted, then 7-seg decoded combinationally from registers.
- Event priority within one cycle: zero > start_stop > lap.
- States:
  IDLE: live time shown. start_stop -> RUN, latching mode; if mode=1 and time=00:00.00, ignore. lap with lap_count>0 -> RECALL at the most recent lap. zero -> time = 00:00.00 (mode=0) or preset (mode=1); laps cleared.
  RUN: counts on tick. start_stop -> IDLE with time held. lap -> current time written to buffer[wr_ptr]; wr_ptr wraps mod LAP_DEPTH and overwrites the oldest; lap_count saturates. zero -> IDLE, with the same clear as in IDLE.
  RECALL: display shows buffer[view]. Each lap event steps view to the next older valid entry and wraps to the newest. start_stop -> IDLE, showing live time. zero -> clear, then IDLE.
  EXPIRED: time frozen at 00:00.00; expired=1. zero -> reload preset, then IDLE. start_stop and lap are ignored.
- A mode change while in RUN has no effect until the next stop and start. A tick coinciding with a stop edge is discarded, so time does not advance on that edge.
- Reset mid-run has the same effect as power-on reset: laps and time are lost.

Test Plan:
- CLOCK_FREQ=100 (DIV=1), mode=0. Reset, start pulse, 250 cycles, stop pulse -> display 00:02.50 held; running=0; time unchanged for 100 further cycles.
- Up wrap: from 59:59.98, run 3 ticks -> 00:00.01; no expiry.
- Laps: run; lap pulses at 1.00 s, 2.00 s, 3.00 s, 4.00 s, 5.00 s with LAP_DEPTH=4 -> lap_count=4. Stop, then lap pulses -> recall shows 5.00, 4.00, 3.00, 2.00, then 5.00 (1.00 was overwritten).
- Countdown: mode=1, preset 0:02, zero, start -> after 200 ticks, display 00:00.00 and expired=1. Further start pulse -> no change. zero -> 00:02.00, IDLE.
- Simultaneous: start_stop and zero rise in the same cycle while RUN -> IDLE with time cleared, running=0, lap_count=0.
- Divider: CLOCK_FREQ=1000 -> cs increments exactly every 10 cycles, with the first increment 10 cycles after the start edge. Reset asserted mid-run -> all outputs at reset values on the next edge.
